result_serializer: RTL and testbench

- Output stage of the encrypt/authenticate top level; sits directly downstream of the AES-128 core and the HMAC-SHA3 core.
- Captures one 128-bit ciphertext and one 256-bit MAC, then streams them byte-serially on the top-level output bus: cipher burst (16 bytes) first, then MAC burst (32 bytes).
- o_valid deasserts between the two bursts, so each burst starts with its own rising edge of o_valid.

---
 rtl/result_serializer.sv | 167 ++++++++++++++++
 tb/tb_result_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Byte-serial output stage: buffers one 128-bit ciphertext and one 256-bit MAC and streams them
// LSB byte first, cipher burst then MAC burst. Define RESULT_SER_PARITY_EN to add o_parity.
module result_serializer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] i_cipher,
  input  logic         i_cipher_valid,
  output logic         o_cipher_ready,
  input  logic [255:0] i_mac,
  input  logic         i_mac_valid,
  output logic         o_mac_ready,
  output logic [7:0]   o_data,
  output logic         o_valid,
  output logic         o_done
`ifdef RESULT_SER_PARITY_EN
  ,
  output logic         o_parity
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCipher,
    StGap,
    StMacWait,
    StMac,
    StDone
  } state_e;

  localparam logic [4:0] GapLast = 5'(GAP_CYCLES - 1);

  state_e         state_q, state_d;
  logic   [4:0]   cnt_q, cnt_d;
  logic   [127:0] cipher_q;
  logic           cipher_full_q, cipher_full_d;
  logic   [255:0] mac_q;
  logic           mac_full_q, mac_full_d;
  logic           cipher_cap, mac_cap;
  logic           cipher_clr, mac_clr;
  logic   [7:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  assign o_cipher_ready = ~cipher_full_q;
  assign o_mac_ready    = ~mac_full_q;
  assign cipher_cap     = i_cipher_valid & ~cipher_full_q;
  assign mac_cap        = i_mac_valid & ~mac_full_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cipher_clr = 1'b0;
    mac_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cipher_full_q) begin
          state_d = StCipher;
          cnt_d   = '0;
        end
      end
      StCipher: begin
        if (cnt_q == 5'd15) begin
          cnt_d      = '0;
          cipher_clr = 1'b1;
          state_d    = StGap;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = mac_full_q ? StMac : StMacWait;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StMacWait: begin
        if (mac_full_q) begin
          state_d = StMac;
          cnt_d   = '0;
        end
      end
      StMac: begin
        if (cnt_q == 5'd31) begin
          cnt_d   = '0;
          mac_clr = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone: begin
        // A cipher captured during the previous result starts right after the done pulse.
        state_d = cipher_full_q ? StCipher : StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Capture needs an empty buffer and clearing needs a full one, so they never coincide.
    cipher_full_d = cipher_cap ? 1'b1 : (cipher_clr ? 1'b0 : cipher_full_q);
    mac_full_d    = mac_cap ? 1'b1 : (mac_clr ? 1'b0 : mac_full_q);

    // Outputs are registered, so they are decoded from the next state and count.
    valid_d = (state_d == StCipher) || (state_d == StMac);
    done_d  = (state_d == StDone);
    data_d  = 8'h00;
    if (state_d == StCipher) begin
      data_d = cipher_q[{cnt_d[3:0], 3'b000} +: 8];
    end else if (state_d == StMac) begin
      data_d = mac_q[{cnt_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cipher_q      <= '0;
      cipher_full_q <= 1'b0;
      mac_q         <= '0;
      mac_full_q    <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cipher_full_q <= cipher_full_d;
      mac_full_q    <= mac_full_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      if (cipher_cap) begin
        cipher_q <= i_cipher;
      end
      if (mac_cap) begin
        mac_q <= i_mac;
      end
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;

`ifdef RESULT_SER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign o_parity = parity_q;
`endif

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: table of cipher/MAC timing vectors plus hand-built
// back-to-back and mid-burst reset sequences, compared cycle by cycle against a timing model.
module tb_result_serializer;

  localparam int G    = 2;
  localparam int MAXC = 160;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] i_cipher = '0;
  logic         i_cipher_valid = 1'b0;
  logic         o_cipher_ready;
  logic [255:0] i_mac = '0;
  logic         i_mac_valid = 1'b0;
  logic         o_mac_ready;
  logic [7:0]   o_data;
  logic         o_valid;
  logic         o_done;
`ifdef RESULT_SER_PARITY_EN
  logic         o_parity;
`endif

  always #5 clk = ~clk;

  result_serializer #(
    .GAP_CYCLES(G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cipher      (i_cipher),
    .i_cipher_valid(i_cipher_valid),
    .o_cipher_ready(o_cipher_ready),
    .i_mac         (i_mac),
    .i_mac_valid   (i_mac_valid),
    .o_mac_ready   (o_mac_ready),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_done        (o_done)
`ifdef RESULT_SER_PARITY_EN
    ,
    .o_parity      (o_parity)
`endif
  );

  typedef struct {
    string        name;
    logic [127:0] cipher;
    logic [255:0] mac;
    int           c_t;
    int           m_t;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  // Expected output per logged edge, filled by add_pair from the burst timing rules.
  logic [7:0] exp_d    [MAXC];
  logic       exp_v    [MAXC];
  logic       exp_done [MAXC];
  logic       exp_cr   [MAXC];
  logic       exp_mr   [MAXC];

  logic [127:0] c_data [2];
  int           c_time [2];
  int           nc;
  logic [255:0] m_data [2];
  int           m_time [2];
  int           nm;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] pack(logic v, logic [7:0] d, logic dn, logic cr, logic mr,
                                       logic p);
    return {v, d, dn, cr, mr, p};
  endfunction

  function automatic logic [12:0] got_vec();
    logic p;
`ifdef RESULT_SER_PARITY_EN
    p = o_parity;
`else
    p = 1'b0;
`endif
    return pack(o_valid, o_data, o_done, o_cipher_ready, o_mac_ready, p);
  endfunction

  function automatic logic [12:0] exp_vec(int e);
    logic p;
`ifdef RESULT_SER_PARITY_EN
    p = ^exp_d[e];
`else
    p = 1'b0;
`endif
    return pack(exp_v[e], exp_d[e], exp_done[e], exp_cr[e], exp_mr[e], p);
  endfunction

  task automatic check(input string name, input int cyc, input logic [12:0] got,
                       input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got {valid,data,done,crdy,mrdy,par}=%h, expected %h",
               name, cyc, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    i_cipher_valid = 1'b0;
    i_mac_valid    = 1'b0;
    tick();
    tick();
    check("reset_state", 0, got_vec(), pack(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    rst_n = 1'b1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < MAXC; i++) begin
      exp_d[i]    = 8'h00;
      exp_v[i]    = 1'b0;
      exp_done[i] = 1'b0;
      exp_cr[i]   = 1'b1;
      exp_mr[i]   = 1'b1;
    end
    nc = 0;
    nm = 0;
  endtask

  // ecap/emcap: capture edges; cs: log index of the first cipher byte.
  task automatic add_pair(input int ecap, input int cs, input int emcap,
                          input logic [127:0] c, input logic [255:0] m, output int ms);
    ms = (cs + 16 + G > emcap + 1) ? cs + 16 + G : emcap + 1;
    for (int k = 0; k < 16; k++) begin
      exp_v[cs + k] = 1'b1;
      exp_d[cs + k] = c[8*k +: 8];
    end
    for (int k = 0; k < 32; k++) begin
      exp_v[ms + k] = 1'b1;
      exp_d[ms + k] = m[8*k +: 8];
    end
    exp_done[ms + 32] = 1'b1;
    for (int i = ecap; i <= cs + 15; i++) exp_cr[i] = 1'b0;
    for (int i = emcap; i <= ms + 31; i++) exp_mr[i] = 1'b0;
  endtask

  // Upstream holds each valid from its present time until the handshake completes.
  task automatic run(input string name, input int n);
    int  ci;
    int  mi;
    logic cv;
    logic mv;
    logic crdy;
    logic mrdy;
    ci = 0;
    mi = 0;
    for (int e = 0; e < n; e++) begin
      cv = 1'b0;
      mv = 1'b0;
      if (ci < nc) begin
        cv       = (c_time[ci] <= e);
        i_cipher = c_data[ci];
      end
      if (mi < nm) begin
        mv    = (m_time[mi] <= e);
        i_mac = m_data[mi];
      end
      i_cipher_valid = cv;
      i_mac_valid    = mv;
      crdy = o_cipher_ready;
      mrdy = o_mac_ready;
      @(posedge clk);
      if (cv && crdy) ci++;
      if (mv && mrdy) mi++;
      #1;
      check(name, e, got_vec(), exp_vec(e));
    end
    i_cipher_valid = 1'b0;
    i_mac_valid    = 1'b0;
  endtask

  vec_t vecs [6];
  int   ms;
  int   ms1;
  int   ms2;

  initial begin
    vecs[0].name   = "cipher_then_mac";
    vecs[0].cipher = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[0].mac    = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
    vecs[0].c_t    = 0;
    vecs[0].m_t    = 5;
    vecs[1].name   = "mac_first";
    vecs[1].cipher = 128'hdeadbeef_01234567_89abcdef_a5a55a5a;
    vecs[1].mac    = 256'hffeeddcc_bbaa9988_77665544_33221100_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    vecs[1].c_t    = 10;
    vecs[1].m_t    = 0;
    vecs[2].name   = "late_mac";
    vecs[2].cipher = 128'h11111111_22222222_33333333_44444444;
    vecs[2].mac    = 256'hc0ffee00_12345678_9abcdef0_0fedcba9_87654321_00ff00ff_aa55aa55_80402010;
    vecs[2].c_t    = 0;
    vecs[2].m_t    = 36;
    vecs[3].name   = "simultaneous";
    vecs[3].cipher = 128'h80000000_00000000_00000000_00000001;
    vecs[3].mac    = 256'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_000000fe;
    vecs[3].c_t    = 0;
    vecs[3].m_t    = 0;
    vecs[4].name   = "mac_last_gap_edge";
    vecs[4].cipher = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    vecs[4].mac    = 256'h3f3e3d3c_3b3a3938_37363534_33323130_2f2e2d2c_2b2a2928_27262524_23222120;
    vecs[4].c_t    = 0;
    vecs[4].m_t    = 18;
    vecs[5].name   = "mac_one_wait";
    vecs[5].cipher = 128'h5a5a5a5a_a5a5a5a5_ffffffff_00000000;
    vecs[5].mac    = 256'h13579bdf_2468ace0_13579bdf_2468ace0_fedcba98_76543210_fedcba98_76543210;
    vecs[5].c_t    = 0;
    vecs[5].m_t    = 19;

    for (int v = 0; v < 6; v++) begin
      apply_reset();
      clear_exp();
      c_data[0] = vecs[v].cipher;
      c_time[0] = vecs[v].c_t;
      nc        = 1;
      m_data[0] = vecs[v].mac;
      m_time[0] = vecs[v].m_t;
      nm        = 1;
      add_pair(vecs[v].c_t, vecs[v].c_t + 1, vecs[v].m_t, vecs[v].cipher, vecs[v].mac, ms);
      run(vecs[v].name, ms + 35);
    end

    // Second pair presented during the first MAC burst; its MAC waits for the buffer to drain.
    apply_reset();
    clear_exp();
    c_data[0] = vecs[0].cipher;
    c_data[1] = vecs[1].cipher;
    c_time[0] = 0;
    c_time[1] = 25;
    nc        = 2;
    m_data[0] = vecs[0].mac;
    m_data[1] = vecs[1].mac;
    m_time[0] = 0;
    m_time[1] = 25;
    nm        = 2;
    add_pair(0, 1, 0, vecs[0].cipher, vecs[0].mac, ms1);
    add_pair(25, ms1 + 33, ms1 + 33, vecs[1].cipher, vecs[1].mac, ms2);
    run("back_to_back", ms2 + 35);

    // Abort while MAC byte 10 is on the bus, then a fresh pair must start from byte 0.
    apply_reset();
    clear_exp();
    c_data[0] = vecs[2].cipher;
    c_time[0] = 0;
    nc        = 1;
    m_data[0] = vecs[2].mac;
    m_time[0] = 0;
    nm        = 1;
    add_pair(0, 1, 0, vecs[2].cipher, vecs[2].mac, ms);
    run("mid_reset_pre", ms + 11);
    rst_n = 1'b0;
    tick();
    check("mid_reset", 0, got_vec(), pack(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    rst_n = 1'b1;
    clear_exp();
    c_data[0] = vecs[3].cipher;
    c_time[0] = 0;
    nc        = 1;
    m_data[0] = vecs[3].mac;
    m_time[0] = 2;
    nm        = 1;
    add_pair(0, 1, 2, vecs[3].cipher, vecs[3].mac, ms);
    run("after_reset", ms + 35);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
